// File: rtl/gpu_cmd_fetch.sv
// Display-list fetch engine feeding the GPU line rasterizer.
// Reads packed line commands over a Wishbone read master and programs the
// rasterizer through a second Wishbone master, polling its FIFO count
// before every command so nothing is pushed into a full FIFO.
module gpu_cmd_fetch #(
  parameter int RASTER_FIFO_DEPTH = 16,
  parameter int MAX_CMDS          = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic        d_cyc_o,
  output logic        d_stb_o,
  output logic [31:0] d_adr_o,
  input  logic [31:0] d_dat_i,
  input  logic        d_ack_i,
  output logic        r_cyc_o,
  output logic        r_stb_o,
  output logic        r_we_o,
  output logic [3:0]  r_sel_o,
  output logic [31:0] r_adr_o,
  output logic [31:0] r_dat_o,
  input  logic [31:0] r_dat_i,
  input  logic        r_ack_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, POLL, WRITE, START, DONE, ERROR
  } state_t;

  localparam logic [31:0] FIFO_LIMIT = 32'(RASTER_FIFO_DEPTH);
  localparam logic [31:0] CMD_LIMIT  = 32'(MAX_CMDS);

  state_t      state;
  logic [31:0] list_addr, cur_addr, cmd_count;
  logic [8:0]  x0, y0, x1, y1;
  logic        color;
  logic        done, error, irq_en, abort_req;
  logic [2:0]  widx;
  logic [31:0] wr_data;
  logic        s_req, s_wr, start_cmd, abort_cmd, busy;
  logic        unused_bits;

  assign s_req     = s_cyc_i & s_stb_i & ~s_ack_o;
  assign s_wr      = s_req & s_we_i;
  assign start_cmd = s_wr && (s_adr_i[2:0] == 3'd1) && s_dat_i[0];
  assign abort_cmd = s_wr && (s_adr_i[2:0] == 3'd1) && s_dat_i[1];
  assign busy      = (state != IDLE);
  assign irq_o     = irq_en & (done | error);

  assign unused_bits = &{1'b0, s_adr_i[31:3], d_dat_i[31:18], r_dat_i[31:6]};

  // Rasterizer register data for the current step of the five-write burst.
  always_comb begin
    wr_data = '0;
    case (widx)
      3'd0:    wr_data = {23'd0, x0};
      3'd1:    wr_data = {23'd0, y0};
      3'd2:    wr_data = {23'd0, x1};
      3'd3:    wr_data = {23'd0, y1};
      default: wr_data = {31'd0, color};
    endcase
  end

  // CPU slave: one-cycle ack, register writes and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ack_o   <= 1'b0;
      s_dat_o   <= '0;
      list_addr <= '0;
      irq_en    <= 1'b0;
    end else begin
      s_ack_o <= s_req;
      if (s_req) begin
        if (s_we_i) begin
          case (s_adr_i[2:0])
            3'd0:    list_addr <= {s_dat_i[31:2], 2'b00};
            3'd1:    irq_en    <= s_dat_i[2];
            default: ;
          endcase
        end else begin
          case (s_adr_i[2:0])
            3'd0:    s_dat_o <= list_addr;
            3'd1:    s_dat_o <= {29'd0, irq_en, 2'b00};
            3'd2:    s_dat_o <= {29'd0, error, done, busy};
            3'd3:    s_dat_o <= cmd_count;
            3'd4:    s_dat_o <= cur_addr;
            default: s_dat_o <= '0;
          endcase
        end
      end
    end
  end

  // Fetch/issue sequencer; bus outputs are registered and dropped the cycle
  // after ack, so each state re-arms its master only when the bus is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cmd_count <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      abort_req <= 1'b0;
      widx      <= '0;
      x0        <= '0;
      y0        <= '0;
      x1        <= '0;
      y1        <= '0;
      color     <= 1'b0;
      d_cyc_o   <= 1'b0;
      d_stb_o   <= 1'b0;
      d_adr_o   <= '0;
      r_cyc_o   <= 1'b0;
      r_stb_o   <= 1'b0;
      r_we_o    <= 1'b0;
      r_sel_o   <= '0;
      r_adr_o   <= '0;
      r_dat_o   <= '0;
    end else begin
      if (abort_cmd && busy) abort_req <= 1'b1;
      case (state)
        IDLE: begin
          abort_req <= 1'b0;
          if (start_cmd) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cmd_count <= '0;
            cur_addr  <= list_addr;
            state     <= FETCH0;
          end
        end
        default: begin
          // A pending abort is honoured only once neither master has a cycle open.
          if (abort_req && !d_cyc_o && !r_cyc_o) begin
            state     <= IDLE;
            done      <= 1'b0;
            error     <= 1'b0;
            abort_req <= 1'b0;
          end else begin
            case (state)
              FETCH0, FETCH1: begin
                if (!d_cyc_o) begin
                  d_cyc_o <= 1'b1;
                  d_stb_o <= 1'b1;
                  d_adr_o <= cur_addr;
                end else if (d_ack_i) begin
                  d_cyc_o  <= 1'b0;
                  d_stb_o  <= 1'b0;
                  d_adr_o  <= '0;
                  cur_addr <= cur_addr + 32'd4;
                  if (state == FETCH0) begin
                    x0    <= d_dat_i[8:0];
                    y0    <= d_dat_i[17:9];
                    color <= d_dat_i[18];
                    case (d_dat_i[31:28])
                      4'h0:    state <= DONE;
                      4'h1:    state <= FETCH1;
                      default: state <= ERROR;
                    endcase
                  end else begin
                    x1    <= d_dat_i[8:0];
                    y1    <= d_dat_i[17:9];
                    state <= POLL;
                  end
                end
              end
              POLL, WRITE, START: begin
                if (!r_cyc_o) begin
                  r_cyc_o <= 1'b1;
                  r_stb_o <= 1'b1;
                  r_sel_o <= '1;
                  r_we_o  <= (state != POLL);
                  r_adr_o <= (state == POLL)  ? 32'd10 :
                             (state == START) ? 32'd5  : {29'd0, widx};
                  r_dat_o <= (state == WRITE) ? wr_data : '0;
                end else if (r_ack_i) begin
                  r_cyc_o <= 1'b0;
                  r_stb_o <= 1'b0;
                  r_we_o  <= 1'b0;
                  r_sel_o <= '0;
                  r_adr_o <= '0;
                  r_dat_o <= '0;
                  if (state == POLL) begin
                    if ({26'd0, r_dat_i[5:0]} < FIFO_LIMIT) begin
                      widx  <= '0;
                      state <= WRITE;
                    end
                  end else if (state == WRITE) begin
                    if (widx == 3'd4) state <= START;
                    else widx <= widx + 3'd1;
                  end else begin
                    cmd_count <= cmd_count + 32'd1;
                    state     <= (cmd_count + 32'd1 == CMD_LIMIT) ? ERROR : FETCH0;
                  end
                end
              end
              DONE: begin
                done  <= 1'b1;
                state <= IDLE;
              end
              ERROR: begin
                error <= 1'b1;
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_fetch.sv
// Scoreboard bench for gpu_cmd_fetch: list memory and rasterizer models,
// expected rasterizer writes queued by the stimulus, popped by a monitor.
module tb_gpu_cmd_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [31:0] s_adr_i, s_dat_i;
  logic        s_ack_o;
  logic [31:0] s_dat_o;
  logic        d_cyc_o, d_stb_o;
  logic [31:0] d_adr_o;
  logic [31:0] d_dat_i = '0;
  logic        d_ack_i = 1'b0;
  logic        r_cyc_o, r_stb_o, r_we_o;
  logic [3:0]  r_sel_o;
  logic [31:0] r_adr_o, r_dat_o;
  logic [31:0] r_dat_i = '0;
  logic        r_ack_i = 1'b0;
  logic        irq_o;

  always #5 clk = ~clk;

  gpu_cmd_fetch #(.RASTER_FIFO_DEPTH(16), .MAX_CMDS(2)) dut (
    .clk(clk), .rst(rst),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
    .s_dat_i(s_dat_i), .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
    .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_adr_o(d_adr_o), .d_dat_i(d_dat_i),
    .d_ack_i(d_ack_i),
    .r_cyc_o(r_cyc_o), .r_stb_o(r_stb_o), .r_we_o(r_we_o), .r_sel_o(r_sel_o),
    .r_adr_o(r_adr_o), .r_dat_o(r_dat_o), .r_dat_i(r_dat_i), .r_ack_i(r_ack_i),
    .irq_o(irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:511];
  logic [31:0] slow_addr  = 32'hFFFF_FFFF;
  int          slow_delay = 0;
  int          d_wait     = 0;
  int          poll_cnt   = 0;
  int          poll_base  = 0;
  int          full_polls = 0;
  int          min_polls  = 0;
  int          w_cnt      = 0;
  int          r5_cnt     = 0;
  logic [36:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // List memory: zero-wait except at slow_addr, which stalls slow_delay cycles.
  always @(posedge clk) begin
    if (d_cyc_o && d_stb_o && !d_ack_i) begin
      if (d_wait >= ((d_adr_o == slow_addr) ? slow_delay : 0)) begin
        d_ack_i <= 1'b1;
        d_dat_i <= mem[d_adr_o[10:2]];
        d_wait  <= 0;
      end else begin
        d_wait <= d_wait + 1;
      end
    end else begin
      d_ack_i <= 1'b0;
    end
  end

  // Rasterizer: one-cycle ack; reads report a full FIFO for the first full_polls polls.
  always @(posedge clk) begin
    if (r_cyc_o && r_stb_o && !r_ack_i) begin
      r_ack_i <= 1'b1;
      if (!r_we_o) begin
        r_dat_i  <= ((poll_cnt - poll_base) < full_polls) ? 32'd16 : 32'd15;
        poll_cnt <= poll_cnt + 1;
      end
    end else begin
      r_ack_i <= 1'b0;
    end
  end

  // Monitor: every completed rasterizer write is matched against the queue.
  initial forever begin
    logic [36:0] e;
    @(negedge clk);
    if (!rst && r_cyc_o && r_stb_o && r_we_o && r_ack_i) begin
      w_cnt++;
      if (r_adr_o == 32'd5) r5_cnt++;
      check("rast_sel", {28'd0, r_sel_o}, 32'hF);
      if (min_polls > 0 && r_adr_o == 32'd0)
        check("polls_before_write", poll_cnt - poll_base, min_polls);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data %h expected no write", r_adr_o, r_dat_o);
      end else begin
        e = exp_q.pop_front();
        check("rast_adr", r_adr_o, {27'd0, e[36:32]});
        check("rast_dat", r_dat_o, e[31:0]);
      end
    end
  end

  task automatic push_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    exp_q.push_back({5'd0, 32'(x0)});
    exp_q.push_back({5'd1, 32'(y0)});
    exp_q.push_back({5'd2, 32'(x1)});
    exp_q.push_back({5'd3, 32'(y1)});
    exp_q.push_back({5'd4, 32'(c)});
    exp_q.push_back({5'd5, 32'd0});
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = {29'd0, a}; s_dat_i = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_ack_o) begin got = 1; break; end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_write_ack: got s_ack_o=0 expected 1 (reg %0d)", a);
    end
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    bit got = 0;
    d = '0;
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = {29'd0, a};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_ack_o) begin got = 1; d = s_dat_o; break; end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_read_ack: got s_ack_o=0 expected 1 (reg %0d)", a);
    end
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cpu_read(a, v);
    check(name, v, exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st;
    bit idle = 0;
    for (int i = 0; i < 400; i++) begin
      cpu_read(3'd2, st);
      if (!st[0]) begin idle = 1; break; end
    end
    check({name, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    bit held;
    rst = 1'b1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_adr_i = '0; s_dat_i = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    // LINE x0=10 y0=20 c=1 / x1=50 y1=60, END at 0x100
    mem[9'h40] = 32'h1004_280A;
    mem[9'h41] = 32'h0000_7832;
    mem[9'h42] = 32'h0000_0000;
    // bad opcode 3 at 0x200
    mem[9'h80] = 32'h3000_0000;
    // three LINEs at 0x400: (1,2,3,4,c0) (511,511,0,0,c1) (0,0,0,0,c0), END
    mem[9'h100] = 32'h1000_0401; mem[9'h101] = 32'h0000_0803;
    mem[9'h102] = 32'h1007_FFFF; mem[9'h103] = 32'h0000_0000;
    mem[9'h104] = 32'h1000_0000; mem[9'h105] = 32'h0000_0000;
    mem[9'h106] = 32'h0000_0000;

    repeat (3) @(negedge clk);
    check("reset_outputs", {8'd0, d_cyc_o, d_stb_o, r_cyc_o, r_stb_o, r_we_o, r_sel_o,
                            s_ack_o, irq_o, 13'd0}, 32'd0);
    rst = 1'b0;
    check_reg("reset_status", 3'd2, 32'd0);
    check_reg("reset_count", 3'd3, 32'd0);
    check_reg("reset_list_addr", 3'd0, 32'd0);

    // Basic LINE + END
    cpu_write(3'd0, 32'h0000_0103);
    check_reg("list_addr_align", 3'd0, 32'h0000_0100);
    push_cmd(10, 20, 50, 60, 1);
    w0 = w_cnt; r0 = r5_cnt;
    cpu_write(3'd1, 32'd1);
    wait_idle("basic");
    check_reg("basic_status", 3'd2, 32'd2);
    check_reg("basic_count", 3'd3, 32'd1);
    check_reg("basic_cur_addr", 3'd4, 32'h0000_010C);
    check("basic_writes", w_cnt - w0, 6);
    check("basic_queue", exp_q.size(), 0);
    check("basic_irq_off", {31'd0, irq_o}, 32'd0);

    // FIFO full for 7 polls, then count 15
    poll_base = poll_cnt; full_polls = 7; min_polls = 8;
    push_cmd(10, 20, 50, 60, 1);
    r0 = r5_cnt;
    cpu_write(3'd1, 32'd1);
    wait_idle("poll");
    check("poll_count", poll_cnt - poll_base, 8);
    check("poll_reg5_once", r5_cnt - r0, 1);
    check("poll_queue", exp_q.size(), 0);
    full_polls = 0; min_polls = 0;

    // Bad opcode with interrupt enabled
    cpu_write(3'd0, 32'h0000_0200);
    w0 = w_cnt;
    cpu_write(3'd1, 32'd5);
    wait_idle("err");
    check_reg("err_status", 3'd2, 32'd4);
    check("err_irq", {31'd0, irq_o}, 32'd1);
    check("err_no_writes", w_cnt - w0, 0);
    check_reg("err_ctrl_read", 3'd1, 32'd4);
    cpu_write(3'd1, 32'd0);
    check("err_irq_masked", {31'd0, irq_o}, 32'd0);

    // Abort while the second list word is stalled
    cpu_write(3'd0, 32'h0000_0100);
    slow_addr = 32'h0000_0104; slow_delay = 12;
    w0 = w_cnt; r0 = r5_cnt;
    cpu_write(3'd1, 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d_cyc_o && d_adr_o == 32'h104) break;
    end
    check("abort_reach_fetch1", d_adr_o, 32'h0000_0104);
    cpu_write(3'd1, 32'd2);
    held = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_ack_i) break;
      if (!d_cyc_o) held = 0;
    end
    check("abort_cyc_held", {31'd0, held}, 32'd1);
    check("abort_ack_seen", {31'd0, d_ack_i}, 32'd1);
    wait_idle("abort");
    check_reg("abort_status", 3'd2, 32'd0);
    check("abort_no_writes", w_cnt - w0, 0);
    check("abort_no_reg5", r5_cnt - r0, 0);

    // Start while busy is ignored
    slow_delay = 20;
    push_cmd(10, 20, 50, 60, 1);
    cpu_write(3'd1, 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d_cyc_o && d_adr_o == 32'h104) break;
    end
    cpu_write(3'd0, 32'h0000_0300);
    cpu_write(3'd1, 32'd1);
    check_reg("busy_cur_addr", 3'd4, 32'h0000_0104);
    check_reg("busy_count", 3'd3, 32'd0);
    wait_idle("busy");
    check_reg("busy_status", 3'd2, 32'd2);
    check_reg("busy_final_addr", 3'd4, 32'h0000_010C);
    check_reg("busy_final_count", 3'd3, 32'd1);
    check("busy_queue", exp_q.size(), 0);
    slow_addr = 32'hFFFF_FFFF; slow_delay = 0;

    // Reset in the middle of the register writes
    cpu_write(3'd0, 32'h0000_0100);
    push_cmd(10, 20, 50, 60, 1);
    cpu_write(3'd1, 32'd5);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (r_cyc_o && r_we_o) break;
    end
    check("rst_mid_write_reached", {31'd0, r_we_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_d_bus", d_adr_o | {29'd0, d_cyc_o, d_stb_o, 1'b0}, 32'd0);
    check("rst_r_adr_dat", r_adr_o | r_dat_o, 32'd0);
    check("rst_r_ctrl", {25'd0, r_cyc_o, r_stb_o, r_we_o, r_sel_o}, 32'd0);
    check("rst_s_irq", s_dat_o | {30'd0, s_ack_o, irq_o}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    check_reg("rst_status", 3'd2, 32'd0);
    check_reg("rst_list_addr", 3'd0, 32'd0);

    // MAX_CMDS=2 with three LINE commands
    cpu_write(3'd0, 32'h0000_0400);
    push_cmd(1, 2, 3, 4, 0);
    push_cmd(511, 511, 0, 0, 1);
    r0 = r5_cnt;
    cpu_write(3'd1, 32'd1);
    wait_idle("max");
    check_reg("max_status", 3'd2, 32'd4);
    check_reg("max_count", 3'd3, 32'd2);
    check_reg("max_cur_addr", 3'd4, 32'h0000_0410);
    check("max_reg5", r5_cnt - r0, 2);
    check("max_queue", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
